// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR): one register stage per shift-amount bit,
// valid/ready flow control on both sides, carry/zero flags and a pass-through tag.
module pipelined_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned SHW  = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [SHW-1:0]   in_amt_i,
    input  logic [2:0]       in_op_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_carry_o,
    output logic             out_zero_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam logic [2:0] OpLsl = 3'b001;
    localparam logic [2:0] OpLsr = 3'b010;
    localparam logic [2:0] OpAsr = 3'b011;
    localparam logic [2:0] OpRor = 3'b100;

    logic [SHW-1:0]   valid_s;
    logic [SHW-1:0]   carry_s;
    logic [SHW-1:0]   adv;
    logic [WIDTH-1:0] data_s [SHW];
    logic [TAG_W-1:0] tag_s  [SHW];
    logic [SHW-1:0]   amt_s  [SHW-1];
    logic [2:0]       op_s   [SHW-1];

    // adv[k]: the slot after stage k can take its word this cycle.
    always_comb begin
        adv = '0;
        adv[SHW-1] = out_ready_i;
        for (int k = SHW - 2; k >= 0; k--) begin
            adv[k] = ~valid_s[k+1] | adv[k+1];
        end
    end

    assign in_ready_o = (~valid_s[0] | adv[0]) & ~flush_i;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned S = 1 << k;

        logic             src_valid;
        logic             src_carry;
        logic [WIDTH-1:0] src_data;
        logic [SHW-1:0]   src_amt;
        logic [2:0]       src_op;
        logic [TAG_W-1:0] src_tag;
        logic             do_shift;
        logic             load;
        logic [WIDTH-1:0] data_d, data_q;
        logic             carry_d, carry_q;
        logic [TAG_W-1:0] tag_q;
        logic             valid_q;

        if (k == 0) begin : g_src_in
            assign src_valid = in_valid_i;
            assign src_carry = 1'b0;
            assign src_data  = in_data_i;
            assign src_amt   = in_amt_i;
            assign src_op    = in_op_i;
            assign src_tag   = in_tag_i;
        end else begin : g_src_prev
            assign src_valid = valid_s[k-1];
            assign src_carry = carry_s[k-1];
            assign src_data  = data_s[k-1];
            assign src_amt   = amt_s[k-1];
            assign src_op    = op_s[k-1];
            assign src_tag   = tag_s[k-1];
        end

        // The amount is shifted down one bit per stage; only bit 0 is left by the last stage.
        assign do_shift = (k == SHW - 1) ? |src_amt : src_amt[0];
        assign load     = ~valid_q | adv[k];

        always_comb begin
            data_d  = src_data;
            carry_d = src_carry;
            if (do_shift) begin
                case (src_op)
                    OpLsl: begin
                        data_d  = src_data << S;
                        carry_d = src_data[WIDTH-S];
                    end
                    OpLsr: begin
                        data_d  = src_data >> S;
                        carry_d = src_data[S-1];
                    end
                    OpAsr: begin
                        data_d  = $signed(src_data) >>> S;
                        carry_d = src_data[S-1];
                    end
                    OpRor: begin
                        data_d  = (src_data >> S) | (src_data << (WIDTH - S));
                        carry_d = src_data[S-1];
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                carry_q <= 1'b0;
                tag_q   <= '0;
            end else begin
                if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (load) begin
                    valid_q <= src_valid;
                end
                if (load && src_valid && !flush_i) begin
                    data_q  <= data_d;
                    carry_q <= carry_d;
                    tag_q   <= src_tag;
                end
            end
        end

        assign valid_s[k] = valid_q;
        assign carry_s[k] = carry_q;
        assign data_s[k]  = data_q;
        assign tag_s[k]   = tag_q;

        if (k < SHW - 1) begin : g_fwd
            logic [SHW-1:0] amt_q;
            logic [2:0]     op_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    amt_q <= '0;
                    op_q  <= '0;
                end else if (load && src_valid && !flush_i) begin
                    amt_q <= src_amt >> 1;
                    op_q  <= src_op;
                end
            end

            assign amt_s[k] = amt_q;
            assign op_s[k]  = op_q;
        end
    end

    assign out_valid_o = valid_s[SHW-1];
    assign out_data_o  = data_s[SHW-1];
    assign out_carry_o = carry_s[SHW-1];
    assign out_tag_o   = tag_s[SHW-1];
    // Gated by valid so the flag reads 0 out of reset.
    assign out_zero_o  = valid_s[SHW-1] & ~|data_s[SHW-1];

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter. Supports LSL, LSR, ASR and ROR.
- One log-stage per pipeline register, with a valid/ready handshake on both sides.
- Produces carry-out and zero flags, and carries a tag alongside each operation.
- Sits between the operand-fetch/EX issue logic and writeback. The tag carries the destination register index, so the shifter can stall independently of the ALU.

Parameters:
- WIDTH, 32, data width; must be a power of 2, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width; also the pipeline depth (one register per stage). Derived parameter; not to be overridden.
- TAG_W, 4, width of the sideband tag carried with each operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear: all in-flight operations are discarded.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the shifter accepts the operation this cycle.
- in_data  input  WIDTH  operand A.
- in_amt  input  SHW  shift amount, unsigned 0..WIDTH-1.
- in_op  input  3  000 none, 001 LSL, 010 LSR, 011 ASR, 100 ROR; 101-111 behave as 000.
- in_tag  input  TAG_W  sideband; returned unchanged.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted out.
- out_zero  output  1  out_data == 0.
- out_tag  output  TAG_W  tag of the operation.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0; out_valid = 0; out_data, out_carry, out_zero and out_tag = 0.
  - in_ready = 1 in the first cycle after reset releases.
  - Reset mid-operation drops every in-flight operation; none ever appears at the output.
- Pipeline structure:
  - SHW register stages. Stage k (k = 0..SHW-1) applies a shift of 2^k when amt[k]=1, otherwise it passes the word through.
  - Each stage register holds data, amt, op, tag, carry and valid.
  - The output of stage SHW-1 drives the out_* ports directly from flops, with no combinational path from the in_* ports.
- Handshake:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - Stage k advances when the next stage is empty or advancing. The last stage advances when out_ready is high.
  - Bubbles collapse: an empty stage accepts data even while a downstream stage stalls.
  - in_ready = !v0 | advance0. The combinational ready chain runs from out_ready to in_ready.
  - Holding: while out_valid & !out_ready, out_* remain stable.
- Latency and throughput:
  - An operation accepted at edge N produces out_valid after edge N+SHW when there is no back-pressure.
  - Throughput is 1 operation per cycle.
- Arithmetic, per stage with shift s = 2^k:
  - LSL: fill with zeros from the LSB.
  - LSR: fill with zeros from the MSB.
  - ASR: fill with the current word's MSB.
  - ROR: bits that leave the LSB re-enter at the MSB.
  - none: pass through unchanged.
- Carry:
  - When a stage shifts, carry is updated:
    - LSL: carry = bit[WIDTH-s] of the stage input.
    - LSR/ASR: carry = bit[s-1] of the stage input.
    - ROR: carry = the new MSB.
  - Carry is cleared at entry, so amt = 0 gives carry = 0.
  - Resulting totals: LSL by n gives A[WIDTH-n]; LSR/ASR by n gives A[n-1]; ROR gives result[WIDTH-1].
- out_zero is computed from the final stage's data as registered. It is combinational from the last stage's flops, never from the inputs.
- flush:
  - Clears all valid bits at the next edge; flush has priority over acceptance.
  - in_ready = 0 during flush. An in_valid held during flush is not accepted.
  - out_valid = 0 the cycle after flush.
- Simultaneous events: an output transfer and an input transfer in the same cycle are legal at full occupancy. No operation is lost or duplicated.
- Out-of-range op (101-111): behaves as none, with carry = 0.

Test Plan:
- WIDTH=32. Accept A=0x8000_0001, amt=1, op=LSL, tag=3 at cycle 0 -> at cycle 5: out_data=0x0000_0002, carry=1, zero=0, tag=3.
- ASR A=0x8000_0000 amt=31 -> 0xFFFF_FFFF, carry=0. LSR same inputs -> 0x0000_0001, carry=0. ROR A=0x0000_00F1 amt=4 -> 0x1000_000F, carry=0.
- Stream 8 back-to-back ops with out_ready=1 -> one result per cycle from cycle 5, in order, tags 0..7 intact.
- Hold out_ready=0 after 2 results -> pipeline fills with 5 entries, in_ready=0; outputs stay stable; release -> all remaining results arrive in order, none lost.
- Assert flush with 3 ops in flight -> out_valid=0 on the next cycle; flushed tags never appear. Pulse rst_n low mid-stream -> all outputs 0 immediately (asynchronous), with no residual results.
- amt=0 with op=LSL and A=0x1234_5678 -> 0x1234_5678, carry=0. Any amt with A=0 -> zero=1. op=110 with amt=7 -> data unchanged, carry=0.
